// File: rtl/multi_digit_counter_display.sv
// N-digit hex/BCD up/down counter with prescaler, parallel load and
// registered active-low seven-segment outputs with leading-zero blanking.
module multi_digit_counter_display #(
   parameter int N_DIGITS   = 4,
   parameter int BCD        = 0,
   parameter int PRESCALE   = 50000000,
   parameter int PRESCALE_W = 26
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    up,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   load_value,
   input  logic                    blank_leading,
   output logic [4*N_DIGITS-1:0]   count,
   output logic [7*N_DIGITS-1:0]   hex,
   output logic                    tick,
   output logic                    wrap
);

   localparam logic [3:0] DMAX = (BCD != 0) ? 4'd9 : 4'd15;
   localparam logic [PRESCALE_W-1:0] PTOP = PRESCALE_W'(PRESCALE - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [4*N_DIGITS-1:0] count_q, count_d;
   logic [7*N_DIGITS-1:0] hex_q, hex_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;

   logic [4*N_DIGITS-1:0] stepped;
   logic [4*N_DIGITS-1:0] loaded;
   logic                  carry;
   logic [3:0]            sdig;
   logic [3:0]            ldig;
   logic [3:0]            hdig;
   logic                  zero_above;
   logic                  step;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign step = enable && (pre_q == PTOP);

   // Ripple carry/borrow: carry still set after the top digit means a wrap.
   always_comb begin
      stepped = count_q;
      carry   = 1'b1;
      sdig    = 4'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         sdig = count_q[4*i +: 4];
         if (carry) begin
            if (up) begin
               if (sdig >= DMAX) begin
                  stepped[4*i +: 4] = 4'd0;
               end else begin
                  stepped[4*i +: 4] = sdig + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (sdig == 4'd0) begin
                  stepped[4*i +: 4] = DMAX;
               end else begin
                  stepped[4*i +: 4] = sdig - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      loaded = load_value;
      ldig   = 4'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         ldig = load_value[4*i +: 4];
         if ((BCD != 0) && (ldig > 4'd9)) begin
            loaded[4*i +: 4] = 4'd9;
         end
      end
   end

   always_comb begin
      pre_d   = pre_q;
      count_d = count_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = loaded;
         pre_d   = '0;
      end else if (step) begin
         count_d = stepped;
         pre_d   = '0;
         tick_d  = 1'b1;
         wrap_d  = carry;
      end else if (enable) begin
         pre_d = pre_q + 1'b1;
      end
   end

   // Walk from the top digit down so blanking stops at the first non-zero.
   always_comb begin
      hex_d      = '0;
      zero_above = 1'b1;
      hdig       = 4'd0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         hdig       = count_q[4*i +: 4];
         zero_above = zero_above && (hdig == 4'd0);
         if (blank_leading && (i != 0) && zero_above) begin
            hex_d[7*i +: 7] = SEG_BLANK;
         end else begin
            hex_d[7*i +: 7] = glyph(hdig);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pre_q   <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         hex_q   <= {N_DIGITS{SEG_ZERO}};
      end else begin
         pre_q   <= pre_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
         hex_q   <= hex_d;
      end
   end

   assign count = count_q;
   assign hex   = hex_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for multi_digit_counter_display: three configurations, directed
// tables and sequences, then random stimulus against an arithmetic model.
module tb_multi_digit_counter_display;

   localparam int NDIG [3] = '{2, 2, 4};
   localparam int BCDP [3] = '{0, 1, 0};
   localparam int PRE  [3] = '{4, 1, 1};

   localparam logic [6:0] GLY [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [3];
   logic        en  [3];
   logic        up  [3];
   logic        ld  [3];
   logic        bl  [3];
   logic [15:0] lv  [3];

   logic [7:0]  cnt_a, cnt_b;
   logic [15:0] cnt_c;
   logic [13:0] hex_a, hex_b;
   logic [27:0] hex_c;
   logic        tk [3];
   logic        wr [3];

   logic [15:0] acnt [3];
   logic [27:0] ahex [3];
   assign acnt[0] = {8'h00, cnt_a};
   assign acnt[1] = {8'h00, cnt_b};
   assign acnt[2] = cnt_c;
   assign ahex[0] = {14'h0, hex_a};
   assign ahex[1] = {14'h0, hex_b};
   assign ahex[2] = hex_c;

   multi_digit_counter_display #(
      .N_DIGITS(2), .BCD(0), .PRESCALE(4), .PRESCALE_W(3)
   ) u_a (
      .clock(clk), .reset_n(rst[0]), .enable(en[0]), .up(up[0]),
      .load(ld[0]), .load_value(lv[0][7:0]), .blank_leading(bl[0]),
      .count(cnt_a), .hex(hex_a), .tick(tk[0]), .wrap(wr[0])
   );

   multi_digit_counter_display #(
      .N_DIGITS(2), .BCD(1), .PRESCALE(1), .PRESCALE_W(1)
   ) u_b (
      .clock(clk), .reset_n(rst[1]), .enable(en[1]), .up(up[1]),
      .load(ld[1]), .load_value(lv[1][7:0]), .blank_leading(bl[1]),
      .count(cnt_b), .hex(hex_b), .tick(tk[1]), .wrap(wr[1])
   );

   multi_digit_counter_display #(
      .N_DIGITS(4), .BCD(0), .PRESCALE(1), .PRESCALE_W(1)
   ) u_c (
      .clock(clk), .reset_n(rst[2]), .enable(en[2]), .up(up[2]),
      .load(ld[2]), .load_value(lv[2]), .blank_leading(bl[2]),
      .count(cnt_c), .hex(hex_c), .tick(tk[2]), .wrap(wr[2])
   );

   // ---------------- reference model (counter as an integer) ----------
   function automatic longint modulus(input int n, input int base);
      longint m = 1;
      for (int i = 0; i < n; i++) m = m * base;
      return m;
   endfunction

   function automatic longint toint(input logic [15:0] c, input int n,
                                    input int base);
      longint v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * base + longint'(c[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [15:0] fromint(input longint v0, input int n,
                                           input int base);
      logic [15:0] r = '0;
      longint v = v0;
      for (int i = 0; i < n; i++) begin
         r[4*i +: 4] = 4'(v % base);
         v = v / base;
      end
      return r;
   endfunction

   function automatic logic [15:0] mstep(input logic [15:0] c, input int n,
                                         input int bcd, input logic u);
      int base = (bcd != 0) ? 10 : 16;
      longint m = modulus(n, base);
      longint v = toint(c, n, base);
      v = u ? (v + 1) % m : (v + m - 1) % m;
      return fromint(v, n, base);
   endfunction

   function automatic logic mwrap(input logic [15:0] c, input int n,
                                  input int bcd, input logic u);
      int base = (bcd != 0) ? 10 : 16;
      longint v = toint(c, n, base);
      return u ? (v == modulus(n, base) - 1) : (v == 0);
   endfunction

   function automatic logic [15:0] msat(input logic [15:0] x, input int n,
                                        input int bcd);
      logic [15:0] r = '0;
      int d;
      for (int i = 0; i < n; i++) begin
         d = int'(x[4*i +: 4]);
         if (bcd != 0 && d > 9) d = 9;
         r[4*i +: 4] = 4'(d);
      end
      return r;
   endfunction

   function automatic logic [27:0] mdisp(input logic [15:0] c, input int n,
                                         input logic b);
      logic [27:0] r = '0;
      for (int i = 0; i < n; i++) begin
         if (b && i > 0 && (c >> (4 * i)) == 16'h0) r[7*i +: 7] = 7'h7F;
         else r[7*i +: 7] = GLY[c[4*i +: 4]];
      end
      return r;
   endfunction

   logic [15:0] mc [3];
   int          mp [3];
   logic        mt [3];
   logic        mw [3];
   logic [27:0] mh [3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst[k]) begin
            mc[k] <= '0;
            mp[k] <= 0;
            mt[k] <= 1'b0;
            mw[k] <= 1'b0;
            mh[k] <= mdisp(16'h0, NDIG[k], 1'b0);
         end else begin
            mh[k] <= mdisp(mc[k], NDIG[k], bl[k]);
            if (ld[k]) begin
               mc[k] <= msat(lv[k], NDIG[k], BCDP[k]);
               mp[k] <= 0;
               mt[k] <= 1'b0;
               mw[k] <= 1'b0;
            end else if (en[k] && mp[k] == PRE[k] - 1) begin
               mc[k] <= mstep(mc[k], NDIG[k], BCDP[k], up[k]);
               mw[k] <= mwrap(mc[k], NDIG[k], BCDP[k], up[k]);
               mt[k] <= 1'b1;
               mp[k] <= 0;
            end else begin
               mp[k] <= en[k] ? mp[k] + 1 : mp[k];
               mt[k] <= 1'b0;
               mw[k] <= 1'b0;
            end
         end
      end
   end

   // ---------------- checking helpers ----------------------------------
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        ld;
      logic [15:0] lv;
      logic        en;
      logic        up;
      logic [15:0] cnt;
      logic        t;
      logic        w;
   } vec_t;

   vec_t tbl [13];

   initial begin
      tbl = '{
         '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0},
         '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0},
         '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0},
         '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1},
         '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1},
         '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0},
         '{1'b1, 16'h00FF, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0},
         '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b0},
         '{1'b1, 16'h0042, 1'b1, 1'b1, 16'h0042, 1'b0, 1'b0},
         '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0043, 1'b1, 1'b0},
         '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0043, 1'b0, 1'b0},
         '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 1'b1, 1'b0},
         '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0}
      };

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0; en[k] = 1'b0; up[k] = 1'b1;
         ld[k] = 1'b0; bl[k] = 1'b0; lv[k] = '0;
      end
      bl[2] = 1'b1;
      ld[2] = 1'b1; lv[2] = 16'h1234; en[2] = 1'b1;
      cycles(2);

      chk("rst_cnt_a", cnt_a, 8'h00);
      chk("rst_hex_a", hex_a, {2{7'b1000000}});
      chk("rst_tick_a", tk[0], 1'b0);
      chk("rst_wrap_a", wr[0], 1'b0);
      chk("rst_cnt_c", cnt_c, 16'h0000);
      chk("rst_hex_c", hex_c, {4{7'b1000000}});
      bl[2] = 1'b0; ld[2] = 1'b0; lv[2] = '0; en[2] = 1'b0;

      // prescaled up counting on u_a
      rst[0] = 1'b1; en[0] = 1'b1; up[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cycles(1);
         chk($sformatf("a_tick_%0d", k), tk[0], (k % 4) == 0);
         if (k == 4) chk("a_cnt_1", cnt_a, 8'h01);
         if (k == 5) chk("a_hex_1", hex_a, {7'b1000000, 7'b1111001});
         if (k == 8) chk("a_cnt_2", cnt_a, 8'h02);
      end
      en[0] = 1'b0;
      cycles(10);
      chk("a_hold_cnt", cnt_a, 8'h02);
      chk("a_hold_hex", hex_a, {7'b1000000, 7'b0100100});
      chk("a_hold_tick", tk[0], 1'b0);
      en[0] = 1'b1; rst[0] = 1'b0;
      cycles(1);
      chk("a_midrst_cnt", cnt_a, 8'h00);
      rst[0] = 1'b1;
      cycles(3);
      chk("a_post_rst_tick3", tk[0], 1'b0);
      chk("a_post_rst_cnt3", cnt_a, 8'h00);
      cycles(1);
      chk("a_post_rst_tick4", tk[0], 1'b1);
      chk("a_post_rst_cnt4", cnt_a, 8'h01);

      // BCD carry, wrap and load saturation on u_b
      rst[1] = 1'b1; ld[1] = 1'b1; lv[1] = 16'h0098;
      cycles(1);
      chk("b_load98", cnt_b, 8'h98);
      chk("b_load_tick", tk[1], 1'b0);
      ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
      cycles(1);
      chk("b_cnt99", cnt_b, 8'h99);
      chk("b_wrap99", wr[1], 1'b0);
      cycles(1);
      chk("b_cnt00", cnt_b, 8'h00);
      chk("b_wrap00", wr[1], 1'b1);
      chk("b_tick00", tk[1], 1'b1);
      cycles(1);
      chk("b_cnt01", cnt_b, 8'h01);
      chk("b_wrap01", wr[1], 1'b0);
      ld[1] = 1'b1; lv[1] = 16'h00AB;
      cycles(1);
      chk("b_satAB", cnt_b, 8'h99);
      lv[1] = 16'h00F3;
      cycles(1);
      chk("b_satF3", cnt_b, 8'h93);
      lv[1] = 16'h0000; up[1] = 1'b0;
      cycles(1);
      ld[1] = 1'b0;
      cycles(1);
      chk("b_down_wrap_cnt", cnt_b, 8'h99);
      chk("b_down_wrap", wr[1], 1'b1);
      en[1] = 1'b0;

      // table-driven vectors on u_c
      rst[2] = 1'b1;
      for (int i = 0; i < 13; i++) begin
         ld[2] = tbl[i].ld; lv[2] = tbl[i].lv;
         en[2] = tbl[i].en; up[2] = tbl[i].up;
         cycles(1);
         chk($sformatf("c_vec%0d_cnt", i), cnt_c, tbl[i].cnt);
         chk($sformatf("c_vec%0d_tick", i), tk[2], tbl[i].t);
         chk($sformatf("c_vec%0d_wrap", i), wr[2], tbl[i].w);
      end
      ld[2] = 1'b0; en[2] = 1'b0; bl[2] = 1'b1;
      cycles(1);
      chk("c_blank_on", hex_c, {{3{7'h7F}}, 7'b0010010});
      bl[2] = 1'b0;
      cycles(1);
      chk("c_blank_off", hex_c, {{3{7'b1000000}}, 7'b0010010});
      ld[2] = 1'b1; lv[2] = 16'h0105;
      cycles(1);
      ld[2] = 1'b0; bl[2] = 1'b1;
      cycles(1);
      chk("c_blank_mid", hex_c,
          {7'h7F, 7'b1111001, 7'b1000000, 7'b0010010});

      // randomized traffic on all three against the model
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 3; k++) begin
            rst[k] = ($urandom % 50) != 0;
            ld[k]  = ($urandom % 8) == 0;
            en[k]  = ($urandom % 8) != 0;
            up[k]  = 1'($urandom);
            bl[k]  = 1'($urandom);
            lv[k]  = 16'($urandom);
         end
         cycles(1);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rnd%0d_cnt_%0d", k, n), acnt[k], mc[k]);
            chk($sformatf("rnd%0d_tick_%0d", k, n), tk[k], mt[k]);
            chk($sformatf("rnd%0d_wrap_%0d", k, n), wr[k], mw[k]);
            chk($sformatf("rnd%0d_hex_%0d", k, n), ahex[k], mh[k]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multi_digit_counter_display.md
Name: multi_digit_counter_display

Overview:
Parametrised successor to the single-digit free-running counter with a seven-segment driver. It provides an N-digit up/down counter in hex or BCD, with a programmable prescaler, parallel load, enable and wrap indication. It also drives N active-low seven-segment digits with optional leading-zero blanking. It sits between the board clock/reset and the hexN display pins, and replaces the ad-hoc counter[29:26] tap.

Parameters:
N_DIGITS, 4, number of 4-bit digits and seven-segment outputs (1..6)
BCD, 0, 0 = each digit counts 0..F; 1 = each digit counts 0..9
PRESCALE, 50000000, clock cycles per count step (>=1)
PRESCALE_W, 26, prescaler width; must satisfy 2^PRESCALE_W >= PRESCALE

Ports:
clock  in  1  system clock, 50 MHz
reset_n  in  1  synchronous active-low reset, sampled on posedge clock
enable  in  1  1 = prescaler runs and steps are taken
up  in  1  count direction: 1 = up, 0 = down; sampled on the step cycle
load  in  1  parallel load strobe
load_value  in  4*N_DIGITS  value to load; digit i is bits [4i+3:4i]
blank_leading  in  1  1 = blank leading zero digits (digit 0 is never blanked)
count  out  4*N_DIGITS  current counter value, registered
hex  out  7*N_DIGITS  segments; digit i is bits [7i+6:7i], bit0=a .. bit6=g, active-low
tick  out  1  one-cycle pulse in the cycle count changes due to a step
wrap  out  1  one-cycle pulse when a step wraps the full counter

Behaviour:
- Reset: all actions happen on the posedge where reset_n=0.
  - count=0, prescaler=0, tick=0, wrap=0.
  - every hex digit = 7'b1000000 (glyph "0").
  - Reset overrides load and enable.
- Prescaler:
  - Counts 0..PRESCALE-1 only while enable=1; holds its value while enable=0.
  - A step fires in the cycle where enable=1 and prescaler==PRESCALE-1; the prescaler returns to 0 on the same edge.
  - PRESCALE=1: a step fires every enabled cycle.
- Step, up:
  - Digit 0 increments. A digit at its maximum (F, or 9 when BCD=1) becomes 0 and carries into the next digit.
  - All digits at maximum -> count becomes 0 and wrap pulses.
- Step, down:
  - Digit 0 decrements. A digit at 0 becomes its maximum and borrows from the next digit.
  - All digits zero -> every digit becomes its maximum and wrap pulses.
- tick and wrap are registered: both are 1 in the cycle after the step edge, i.e. the cycle the new count is visible. Both are 0 otherwise.
- Load:
  - load=1 -> count <= load_value and prescaler <= 0. No tick, no wrap.
  - Load has priority over a coincident step; that step is discarded.
  - BCD=1: any loaded digit >9 is saturated to 9.
- Display:
  - hex is registered from count: 1 cycle latency after count changes (2 cycles after the step edge).
  - Active-low glyphs, 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - blank_leading=1: digit i (i>=1) is driven 7'b1111111 when it and all digits above it are 0. blank_leading=0: no blanking.
- Reset mid-count: count restarts at 0 on the next edge; any pending prescaler progress is lost.
- enable=0: count, prescaler and hex hold. load still takes effect.
- direction change: applies to the next step only; no glitch or extra step.

Test Plan:
- Reset and up stepping (N_DIGITS=2, BCD=0, PRESCALE=4): assert reset_n=0 for 2 cycles, release, enable=1, up=1.
  - count=00, then 01 at 4 cycles after release.
  - tick high exactly 1 cycle per 4.
  - hex[6:0] = 1111001 one cycle after count=01.
- BCD carry and wrap (N_DIGITS=2, BCD=1, PRESCALE=1): load 0x98, then step 2 times.
  - count goes 0x99 -> 0x00.
  - wrap=1 only in the cycle count=0x00.
  - load_value 0xAB loads as 0x99.
- Down borrow (BCD=0, N_DIGITS=2): load 0x10, up=0, 1 step -> 0x0F. Continue stepping from 0x00 -> 0xFF with wrap=1.
- Load vs step collision (PRESCALE=1): load=1 with load_value=0x42 in a step cycle -> count=0x42, tick=0. The next step gives 0x43.
- Blanking (N_DIGITS=4): count=0x0005, blank_leading=1 -> digits 3..1 = 1111111, digit0 = 0010010. blank_leading=0 -> digits 3..1 = 1000000.
- Enable hold and mid-operation reset: enable=0 for 10 cycles -> count and hex unchanged. reset_n=0 while the prescaler is at 2 -> count=0, and the next step comes a full PRESCALE cycles after release.
